// File: rtl/wb_ram_bist_master.sv
// wb_ram_bist_master: Wishbone master that writes a seeded pattern to a RAM window, reads it back and reports errors
module wb_ram_bist_master #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          WORDS     = 256,
   parameter int          TIMEOUT   = 15
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        start_i,
   input  logic [31:0] seed_i,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic        timeout_o,
   output logic [15:0] err_count_o,
   output logic [31:0] first_err_addr_o
);
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, DONE} state_t;
   state_t state, nxt;
   logic [15:0] idx, err;
   logic [31:0] seed, first_err, pat, adr;
   logic [7:0]  wait_cnt;
   logic        rd, tmo;
   logic        req, ack, go, expired, last, mismatch;

   assign req      = state == WR_REQ || state == RD_REQ;
   assign ack      = req && wbm_ack_i;
   assign go       = (state == IDLE || state == DONE) && start_i;
   assign expired  = req && !wbm_ack_i && wait_cnt == 8'(TIMEOUT - 1);
   assign last     = idx == 16'(WORDS - 1);
   assign pat      = {~idx, idx} ^ seed;
   assign adr      = BASE_ADDR + {16'h0, idx};
   assign mismatch = state == RD_REQ && ack && wbm_dat_i != pat;

   always_ff @(posedge wb_clk_i)
      state <= !wb_rst_ni ? IDLE : nxt;

   // the single gap state serves both phases; rd tells which phase it returns to
   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE: nxt = start_i ? WR_REQ : state;
         WR_REQ:     nxt = ack ? WR_GAP : expired ? DONE : WR_REQ;
         WR_GAP:     nxt = (rd || last) ? RD_REQ : WR_REQ;
         RD_REQ:     nxt = ack ? (last ? DONE : WR_GAP) : expired ? DONE : RD_REQ;
         default:    nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni || go) begin
         seed      <= wb_rst_ni ? seed_i : 32'h0;
         idx       <= 16'h0;
         err       <= 16'h0;
         first_err <= 32'h0;
         wait_cnt  <= 8'h0;
         rd        <= 1'b0;
         tmo       <= 1'b0;
      end else begin
         wait_cnt <= (req && !wbm_ack_i) ? wait_cnt + 8'd1 : 8'd0;
         if (expired)
            tmo <= 1'b1;
         if (mismatch) begin
            err <= &err ? err : err + 16'd1;
            if (err == 16'h0)
               first_err <= adr;
         end
         if (state == WR_GAP) begin
            idx <= (!rd && last) ? 16'h0 : idx + 16'd1;
            rd  <= rd || last;
         end
      end
   end

   always_comb begin
      wbm_cyc_o        = req;
      wbm_stb_o        = req;
      wbm_we_o         = state == WR_REQ;
      wbm_sel_o        = req ? 4'hF : 4'h0;
      wbm_adr_o        = req ? adr : 32'h0;
      wbm_dat_o        = state == WR_REQ ? pat : 32'h0;
      busy_o           = req || state == WR_GAP;
      done_o           = state == DONE;
      pass_o           = state == DONE && err == 16'h0 && !tmo;
      timeout_o        = tmo;
      err_count_o      = err;
      first_err_addr_o = first_err;
   end
endmodule

// File: tb/tb_wb_ram_bist_master.sv
// tb_wb_ram_bist_master: drives BIST runs against a small behavioural RAM slave and checks results against a pattern model
module tb_wb_ram_bist_master;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int W   = 4;
   localparam int TMO = 15;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] seed_i = 32'h0;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic        busy_o, done_o, pass_o, timeout_o;
   logic [15:0] err_count_o;
   logic [31:0] first_err_addr_o;

   logic [31:0]  mem [0:3];
   int           lat = 0;
   bit           no_ack = 1'b0;
   bit           stuck = 1'b0;
   int           wcyc = 0;
   int           checks = 0;
   int           errors = 0;
   logic [31:0]  wr_adr [$];
   logic [31:0]  wr_dat [$];
   int           unstable, stb_cycles;
   logic         s_busy, s_done;
   logic [15:0]  s_err;
   logic [31:0]  off;
   logic [122:0] all_out;

   wb_ram_bist_master #(.BASE_ADDR(BASE), .WORDS(W), .TIMEOUT(TMO)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .start_i(start_i), .seed_i(seed_i),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
      .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // slave: acks after `lat` wait cycles; word 1 can have its bit 0 stuck at 0
   assign off       = wbm_adr_o - BASE;
   assign wbm_ack_i = wbm_stb_o && !no_ack && wcyc >= lat;
   assign wbm_dat_i = off < 32'd4 ? mem[off[1:0]] & ((stuck && off == 32'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF) : 32'h0;
   assign all_out   = {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
                       busy_o, done_o, pass_o, timeout_o, err_count_o, first_err_addr_o};

   always @(posedge wb_clk_i) begin
      wcyc <= (wbm_stb_o && !wbm_ack_i) ? wcyc + 1 : 0;
      if (wbm_stb_o && wbm_ack_i && wbm_we_o && off < 32'd4)
         mem[off[1:0]] <= wbm_dat_o;
   end

   function automatic logic [31:0] pat(input logic [31:0] s, input int k);
      logic [15:0] i16;
      i16 = 16'(k);
      return {~i16, i16} ^ s;
   endfunction

   function automatic int exp_errs(input logic [31:0] s, input bit stk);
      int e = 0;
      logic [31:0] p;
      for (int k = 0; k < W; k++) begin
         p = pat(s, k);
         if (stk && k == 1 && (p & 32'hFFFF_FFFE) != p)
            e++;
      end
      return e;
   endfunction

   // start a run and follow it cycle by cycle until done_o; n is the cycle (1 = first after the sampling edge) where done_o is seen
   task automatic run_bist(input logic [31:0] s, input int l, input bit na, input bit stk, input int pulse_at, output int n);
      logic [64:0] prev = '0;
      logic pstb = 1'b0;
      logic pack = 1'b0;
      bit found = 1'b0;
      lat = l;
      no_ack = na;
      stuck = stk;
      wr_adr.delete();
      wr_dat.delete();
      unstable = 0;
      stb_cycles = 0;
      n = 0;
      @(negedge wb_clk_i);
      start_i = 1'b1;
      seed_i = s;
      @(negedge wb_clk_i);
      start_i = 1'b0;
      seed_i = $urandom;
      for (int c = 1; c <= 2000 && !found; c++) begin
         n = c;
         if (c == 1) begin
            s_busy = busy_o;
            s_done = done_o;
            s_err = err_count_o;
         end
         if (done_o)
            found = 1'b1;
         else begin
            if (wbm_stb_o)
               stb_cycles++;
            if (wbm_stb_o && pstb && !pack && {wbm_adr_o, wbm_dat_o, wbm_we_o} !== prev)
               unstable++;
            if (wbm_stb_o && wbm_ack_i && wbm_we_o) begin
               wr_adr.push_back(wbm_adr_o);
               wr_dat.push_back(wbm_dat_o);
            end
            pstb = wbm_stb_o;
            pack = wbm_ack_i;
            prev = {wbm_adr_o, wbm_dat_o, wbm_we_o};
            start_i = (c == pulse_at);
            seed_i = $urandom;
            @(negedge wb_clk_i);
         end
      end
      start_i = 1'b0;
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL run_done: done_o=%b after %0d cycles, required 1", done_o, n);
      end
   endtask

   task automatic test_reset;
      int bad = 0;
      wb_rst_ni = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      checks++;
      if (all_out !== 123'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, required 0", all_out);
      end
      wb_rst_ni = 1'b1;
      repeat (5) begin
         @(negedge wb_clk_i);
         if (busy_o !== 1'b0 || wbm_cyc_o !== 1'b0 || done_o !== 1'b0)
            bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reset_idle: %0d active cycles without start, required 0", bad);
      end
   endtask

   task automatic test_zero_wait;
      int n;
      logic [31:0] s;
      run_bist(32'hA5A5_0000, 0, 1'b0, 1'b0, 0, n);
      checks++;
      if (n !== 4 * W) begin
         errors++;
         $display("FAIL zw_done_cycle: got %0d, required %0d", n, 4 * W);
      end
      checks++;
      if (s_busy !== 1'b1) begin
         errors++;
         $display("FAIL zw_busy_first: got %b, required 1", s_busy);
      end
      checks++;
      if ({pass_o, timeout_o, err_count_o} !== {1'b1, 1'b0, 16'h0}) begin
         errors++;
         $display("FAIL zw_result: pass=%b timeout=%b err=%0d, required 1 0 0", pass_o, timeout_o, err_count_o);
      end
      checks++;
      if (wr_adr.size() !== W) begin
         errors++;
         $display("FAIL zw_write_count: got %0d, required %0d", wr_adr.size(), W);
      end else begin
         checks++;
         if ({wr_adr[0], wr_dat[0], wr_adr[1], wr_dat[1]} !== {32'h3000_0000, 32'h5A5A_0000, 32'h3000_0001, 32'h5A5B_0001}) begin
            errors++;
            $display("FAIL zw_first_writes: got %h/%h %h/%h, required 30000000/5a5a0000 30000001/5a5b0001",
                     wr_adr[0], wr_dat[0], wr_adr[1], wr_dat[1]);
         end
      end
      repeat (3) begin
         s = $urandom;
         run_bist(s, 0, 1'b0, 1'b0, 0, n);
         checks++;
         if (n !== 4 * W || pass_o !== 1'b1) begin
            errors++;
            $display("FAIL zw_rand_run: seed %h cycles %0d pass %b, required %0d 1", s, n, pass_o, 4 * W);
         end
         for (int k = 0; k < wr_adr.size(); k++) begin
            checks++;
            if (wr_adr[k] !== BASE + 32'(k) || wr_dat[k] !== pat(s, k)) begin
               errors++;
               $display("FAIL zw_rand_write%0d: got %h/%h, required %h/%h", k, wr_adr[k], wr_dat[k], BASE + 32'(k), pat(s, k));
            end
         end
      end
   endtask

   task automatic test_stuck_bit;
      int n, e;
      logic [31:0] s;
      for (int r = 0; r < 4; r++) begin
         s = (r == 0) ? 32'hA5A5_0000 : $urandom;
         e = exp_errs(s, 1'b1);
         run_bist(s, 0, 1'b0, 1'b1, 0, n);
         checks++;
         if (err_count_o !== 16'(e) || first_err_addr_o !== (e != 0 ? BASE + 32'd1 : 32'h0) || pass_o !== (e == 0)) begin
            errors++;
            $display("FAIL stuck_result: seed %h err %0d addr %h pass %b, required %0d %h %b",
                     s, err_count_o, first_err_addr_o, pass_o, e, (e != 0 ? BASE + 32'd1 : 32'h0), e == 0);
         end
      end
   endtask

   task automatic test_timeout;
      int n;
      run_bist($urandom, 0, 1'b1, 1'b0, 0, n);
      checks++;
      if (stb_cycles !== TMO || n !== TMO + 1) begin
         errors++;
         $display("FAIL to_stb_cycles: stb %0d done at %0d, required %0d %0d", stb_cycles, n, TMO, TMO + 1);
      end
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, timeout_o, done_o, pass_o, busy_o} !== 6'b001100) begin
         errors++;
         $display("FAIL to_status: cyc stb to done pass busy = %b, required 001100",
                  {wbm_cyc_o, wbm_stb_o, timeout_o, done_o, pass_o, busy_o});
      end
   endtask

   task automatic test_latency;
      int n;
      run_bist($urandom, 3, 1'b0, 1'b0, 0, n);
      checks++;
      if (unstable !== 0) begin
         errors++;
         $display("FAIL lat_stable: %0d changes while waiting, required 0", unstable);
      end
      checks++;
      if (n !== 4 * W + 2 * W * 3 || pass_o !== 1'b1 || timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL lat_result: cycles %0d pass %b timeout %b, required %0d 1 0", n, pass_o, timeout_o, 4 * W + 6 * W);
      end
   endtask

   task automatic test_reset_mid_write;
      int n;
      bit found = 1'b0;
      lat = 3;
      no_ack = 1'b0;
      stuck = 1'b0;
      @(negedge wb_clk_i);
      start_i = 1'b1;
      seed_i = $urandom;
      @(negedge wb_clk_i);
      start_i = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (wbm_stb_o && wbm_we_o && wbm_adr_o == BASE + 32'd2)
            found = 1'b1;
         else
            @(negedge wb_clk_i);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rst_mid_reach: word 2 write seen %b, required 1", found);
      end
      wb_rst_ni = 1'b0;
      @(negedge wb_clk_i);
      checks++;
      if (all_out !== 123'h0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got %h, required 0", all_out);
      end
      wb_rst_ni = 1'b1;
      @(negedge wb_clk_i);
      run_bist($urandom, 0, 1'b0, 1'b0, 0, n);
      checks++;
      if (pass_o !== 1'b1 || n !== 4 * W) begin
         errors++;
         $display("FAIL rst_mid_rerun: pass %b cycles %0d, required 1 %0d", pass_o, n, 4 * W);
      end
   endtask

   task automatic test_restart;
      int n;
      logic [31:0] s;
      s = $urandom & 32'hFFFF_FFFE;
      run_bist(s, 0, 1'b0, 1'b1, 5, n);
      checks++;
      if (n !== 4 * W || err_count_o !== 16'd1 || first_err_addr_o !== BASE + 32'd1) begin
         errors++;
         $display("FAIL restart_ignored: cycles %0d err %0d addr %h, required %0d 1 %h", n, err_count_o, first_err_addr_o, 4 * W, BASE + 32'd1);
      end
      checks++;
      if (wr_dat.size() !== W || wr_dat[W-1] !== pat(s, W - 1)) begin
         errors++;
         $display("FAIL restart_seed_kept: last write %h, required %h", wr_dat[W-1], pat(s, W - 1));
      end
      run_bist($urandom, 0, 1'b0, 1'b0, 0, n);
      checks++;
      if ({s_busy, s_done, s_err} !== {1'b1, 1'b0, 16'h0}) begin
         errors++;
         $display("FAIL restart_cleared: busy %b done %b err %0d, required 1 0 0", s_busy, s_done, s_err);
      end
      checks++;
      if (pass_o !== 1'b1 || err_count_o !== 16'h0 || first_err_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL restart_second_run: pass %b err %0d addr %h, required 1 0 0", pass_o, err_count_o, first_err_addr_o);
      end
   endtask

   initial begin
      test_reset;
      test_zero_wait;
      test_stuck_bit;
      test_timeout;
      test_latency;
      test_reset_mid_write;
      test_restart;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
